// File: rtl/mc_request_queue.sv
// In-order request queue between the CPU/trace front end and the DDR5 scheduler.
// Optional statistics outputs are enabled by defining MC_REQ_QUEUE_STATS_EN.
module mc_request_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 34,
    parameter int TIME_W = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_W-1:0]          in_time,
    input  logic [1:0]                 in_opcode,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_opcode,
    output logic [15:0]                out_row,
    output logic [7:0]                 out_hcol,
    output logic [1:0]                 out_bank,
    output logic [1:0]                 out_bg,
    output logic [2:0]                 out_lcol,
    output logic [TIME_W-1:0]          out_time,
    output logic [TIME_W-1:0]          cycle_now,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       err_opcode
`ifdef MC_REQ_QUEUE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]     stat_hiwater,
    output logic [31:0]                stat_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TIME_W-1:0] t;
        logic [1:0]        op;
        logic [15:0]       row;
        logic [6:0]        hcol;
        logic [1:0]        bank;
        logic [1:0]        bg;
        logic [2:0]        lcol;
    } entry_t;

    entry_t             mem_r [DEPTH];
    entry_t             head_s;
    entry_t             new_entry_s;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [TIME_W-1:0]  cycle_r;
    logic               err_r;
    logic               empty_s;
    logic               full_s;
    logic               eligible_s;
    logic               push_s;
    logic               store_s;
    logic               pop_s;
    logic               unused_addr_s;

    // Handshake qualification and head eligibility, all from registered state
    always_comb begin
        empty_s    = (count_r == CNT_W'(0));
        full_s     = (count_r == CNT_W'(DEPTH));
        head_s     = mem_r[rd_ptr_r];
        eligible_s = !empty_s && (cycle_r >= head_s.t);
        push_s     = in_valid && !full_s;
        store_s    = push_s && (in_opcode != 2'd3);
        pop_s      = eligible_s && out_ready;
    end

    // Address decode at push time; byte select and addr[8] are not kept
    always_comb begin
        new_entry_s.t    = in_time;
        new_entry_s.op   = in_opcode;
        new_entry_s.row  = in_addr[33:18];
        new_entry_s.hcol = in_addr[17:11];
        new_entry_s.bank = in_addr[10:9];
        new_entry_s.bg   = in_addr[7:6];
        new_entry_s.lcol = in_addr[5:3];
    end

    assign unused_addr_s = ^{in_addr[8], in_addr[2:0]};

    // Entry storage; contents are don't-care after reset, so no reset here
    always_ff @(posedge clock) begin
        if (store_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Pointers, occupancy, cycle counter and illegal-opcode pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            cycle_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            cycle_r <= cycle_r + TIME_W'(1);
            err_r   <= push_s && (in_opcode == 2'd3);
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head fields are forced to zero while empty so nothing is X after reset
    always_comb begin
        if (empty_s) begin
            out_opcode = 2'd0;
            out_row    = 16'd0;
            out_hcol   = 8'd0;
            out_bank   = 2'd0;
            out_bg     = 2'd0;
            out_lcol   = 3'd0;
            out_time   = '0;
        end else begin
            out_opcode = head_s.op;
            out_row    = head_s.row;
            out_hcol   = {1'b0, head_s.hcol};
            out_bank   = head_s.bank;
            out_bg     = head_s.bg;
            out_lcol   = head_s.lcol;
            out_time   = head_s.t;
        end
    end

    assign in_ready   = !full_s;
    assign out_valid  = eligible_s;
    assign cycle_now  = cycle_r;
    assign count      = count_r;
    assign full       = full_s;
    assign empty      = empty_s;
    assign err_opcode = err_r;

`ifdef MC_REQ_QUEUE_STATS_EN
    logic [CNT_W-1:0] hiwater_r;
    logic [31:0]      stall_r;

    // High-water mark and saturating back-pressure cycle count
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hiwater_r <= '0;
            stall_r   <= 32'd0;
        end else begin
            if (count_r > hiwater_r) begin
                hiwater_r <= count_r;
            end
            if (in_valid && full_s && (stall_r != 32'hFFFF_FFFF)) begin
                stall_r <= stall_r + 32'd1;
            end
        end
    end

    assign stat_hiwater = hiwater_r;
    assign stat_stall   = stall_r;
`endif

endmodule

// File: tb/tb_mc_request_queue.sv
// Scoreboard bench for mc_request_queue: expected requests queued at push, compared at pop.
module tb_mc_request_queue;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_time;
    logic [1:0]  in_opcode;
    logic [33:0] in_addr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_opcode;
    logic [15:0] out_row;
    logic [7:0]  out_hcol;
    logic [1:0]  out_bank;
    logic [1:0]  out_bg;
    logic [2:0]  out_lcol;
    logic [63:0] out_time;
    logic [63:0] cycle_now;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        err_opcode;
`ifdef MC_REQ_QUEUE_STATS_EN
    logic [4:0]  stat_hiwater;
    logic [31:0] stat_stall;
`endif

    mc_request_queue dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time),
        .in_opcode(in_opcode), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_row(out_row), .out_hcol(out_hcol), .out_bank(out_bank),
        .out_bg(out_bg), .out_lcol(out_lcol), .out_time(out_time),
        .cycle_now(cycle_now), .count(count), .full(full), .empty(empty),
        .err_opcode(err_opcode)
`ifdef MC_REQ_QUEUE_STATS_EN
        , .stat_hiwater(stat_hiwater), .stat_stall(stat_stall)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] t;
        logic [1:0]  op;
        logic [33:0] addr;
    } req_t;

    req_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [63:0] model_cycle;
    logic        err_pend;
    logic [63:0] last_pop_cycle;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, check, update model, advance.
    task automatic cyc(input logic v, input logic [63:0] t, input logic [1:0] op,
                       input logic [33:0] a, input logic rdy);
        logic exp_valid;
        logic push_ok;
        req_t r;
        in_valid  = v;
        in_time   = t;
        in_opcode = op;
        in_addr   = a;
        out_ready = rdy;
        #1;
        exp_valid = (sb.size() > 0) && (model_cycle >= sb[0].t);
        push_ok   = v && (sb.size() < 16);
        check("count", 64'(count), 64'(sb.size()));
        check("cycle_now", cycle_now, model_cycle);
        check("out_valid", 64'(out_valid), 64'(exp_valid));
        check("in_ready", 64'(in_ready), 64'(sb.size() < 16));
        check("full", 64'(full), 64'(sb.size() == 16));
        check("empty", 64'(empty), 64'(sb.size() == 0));
        check("err_opcode", 64'(err_opcode), 64'(err_pend));
        if (exp_valid && rdy) begin
            r = sb.pop_front();
            check("pop_op", 64'(out_opcode), 64'(r.op));
            check("pop_row", 64'(out_row), 64'(r.addr[33:18]));
            check("pop_hcol", 64'(out_hcol), 64'({1'b0, r.addr[17:11]}));
            check("pop_bank", 64'(out_bank), 64'(r.addr[10:9]));
            check("pop_bg", 64'(out_bg), 64'(r.addr[7:6]));
            check("pop_lcol", 64'(out_lcol), 64'(r.addr[5:3]));
            check("pop_time", out_time, r.t);
            last_pop_cycle = model_cycle;
        end
        err_pend = 1'b0;
        if (push_ok) begin
            if (op == 2'd3) begin
                err_pend = 1'b1;
            end else begin
                r.t = t;
                r.op = op;
                r.addr = a;
                sb.push_back(r);
            end
        end
        @(posedge clock);
        model_cycle = model_cycle + 64'd1;
        @(negedge clock);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 400) begin
            cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b1);
            guard++;
        end
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    function automatic logic [33:0] rnd_addr();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        return w[33:0];
    endfunction

    logic [33:0] held_addr;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_time = 64'd0; in_opcode = 2'd0;
        in_addr = 34'd0; out_ready = 1'b0;
        err_pend = 1'b0; model_cycle = 64'd0; last_pop_cycle = 64'd0;
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_row", 64'(out_row), 64'd0);
        check("rst_cycle", cycle_now, 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_cycle = 64'd0;

        // Basic push/decode with immediate eligibility
        cyc(1'b1, 64'd0, 2'd0, 34'h0_0004_06C0, 1'b0);
        #1;
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_row", 64'(out_row), 64'h0001);
        check("t1_hcol", 64'(out_hcol), 64'h00);
        check("t1_bank", 64'(out_bank), 64'd3);
        check("t1_bg", 64'(out_bg), 64'd3);
        check("t1_lcol", 64'(out_lcol), 64'd0);
        cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b1);

        // Future-timed request waits for its arrival cycle
        for (int i = 0; i < 20 && model_cycle < 64'd10; i++) begin
            cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b1);
        end
        cyc(1'b1, 64'd100, 2'd1, rnd_addr(), 1'b1);
        drain("t2_drained");
        check("t2_pop_cycle", last_pop_cycle, 64'd100);

        // Fill to 16, hold the 17th, simultaneous pop while full
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 64'd0, 2'(i % 3), rnd_addr(), 1'b0);
        end
        #1;
        check("t3_full", 64'(full), 64'd1);
        check("t3_in_ready", 64'(in_ready), 64'd0);
        check("t3_count", 64'(count), 64'd16);
        held_addr = rnd_addr();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 64'd0, 2'd1, held_addr, 1'b0);
        end
        cyc(1'b1, 64'd0, 2'd1, held_addr, 1'b1);
        #1;
        check("t4_count_after_pop", 64'(count), 64'd15);
        cyc(1'b1, 64'd0, 2'd1, held_addr, 1'b0);
        #1;
        check("t4_count_after_push", 64'(count), 64'd16);
`ifdef MC_REQ_QUEUE_STATS_EN
        check("stat_hiwater", 64'(stat_hiwater), 64'd16);
        check("stat_stall_ge1", 64'(stat_stall >= 32'd1), 64'd1);
`endif
        drain("t3_drained");

        // Illegal opcode is consumed and flagged for one cycle
        cyc(1'b1, 64'd0, 2'd3, rnd_addr(), 1'b0);
        #1;
        check("t5_err", 64'(err_opcode), 64'd1);
        check("t5_count", 64'(count), 64'd0);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b0);
        cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b0);

        // Head-of-line blocking with a mixed random stream
        cyc(1'b1, model_cycle + 64'd20, 2'd0, rnd_addr(), 1'b1);
        cyc(1'b1, 64'd0, 2'd2, rnd_addr(), 1'b1);
        for (int i = 0; i < 40; i++) begin
            cyc($urandom_range(0, 1) == 1, model_cycle + 64'($urandom_range(0, 6)),
                2'($urandom_range(0, 3)), rnd_addr(), $urandom_range(0, 2) != 0);
        end
        drain("t7_drained");

        // Asynchronous reset in the middle of a handshake
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 64'd0, 2'd0, rnd_addr(), 1'b0);
        end
        in_valid = 1'b1; out_ready = 1'b1; in_addr = rnd_addr();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_out_valid", 64'(out_valid), 64'd0);
        check("t6_cycle", cycle_now, 64'd0);
        check("t6_empty", 64'(empty), 64'd1);
        check("t6_out_row", 64'(out_row), 64'd0);
        sb.delete();
        err_pend = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        model_cycle = 64'd0;
        cyc(1'b0, 64'd0, 2'd0, 34'd0, 1'b0);
        cyc(1'b1, 64'd0, 2'd2, rnd_addr(), 1'b0);
        drain("t6_post_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
